// File: rtl/square_meter_pkg.sv
// Shared types and helpers for the square-wave period/duty meter.
package square_meter_pkg;

  // Per-channel measurement state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } ch_state_t;

  localparam int DEF_CNT_W = 32;
  localparam int DEF_N_W   = 16;

  // Converts a clock frequency into a timeout of 1/div second, never below one cycle.
  function automatic int clk_to_timeout(input int clk_hz, input int div);
    int cyc;
    cyc = (div > 0) ? clk_hz / div : clk_hz;
    return (cyc < 1) ? 1 : cyc;
  endfunction

endpackage

// File: rtl/square_wave_meter_ch.sv
// One measurement channel: synchroniser, rise detect, window FSM, counters and flags.
module square_wave_meter_ch
  import square_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int N_W         = DEF_N_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 20_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             wave_in,
  input  logic             start,
  input  logic [N_W-1:0]   n_req,
  input  logic             cont_mode,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             overflow,
  output logic [CNT_W-1:0] period_total,
  output logic [CNT_W-1:0] high_total
);

  localparam int               GAP_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam int               NW1       = N_W + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;
  logic                   rise;

  ch_state_t        state_q, state_d;
  logic [N_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] tot_q, tot_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             timeout_q, timeout_d;
  logic             overflow_q, overflow_d;
  logic             accumulate;

  logic [CNT_W-1:0] tot_inc;
  logic [CNT_W-1:0] hi_inc;
  logic [GAP_W-1:0] gap_inc;
  logic             gap_hit;
  logic [N_W:0]     edge_inc;
  logic             last_edge;

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;

  // Counters stick at all-ones instead of wrapping so a saturated result stays recognisable.
  assign tot_inc   = (tot_q == CNT_MAX) ? tot_q : tot_q + CNT_W'(1);
  assign hi_inc    = (hi_q == CNT_MAX) ? hi_q : hi_q + CNT_W'(level);
  assign gap_inc   = gap_q + GAP_W'(1);
  assign gap_hit   = (gap_inc >= GAP_LIMIT);
  assign edge_inc  = {1'b0, edge_cnt_q} + NW1'(1);
  assign last_edge = (edge_inc >= {1'b0, n_req});

  // Bring the asynchronous input into the clock domain and keep the previous level for rise detect.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], wave_in};
      prev_q <= level;
    end
  end

  // Next-state and datapath update; a start always wins over anything the channel is doing.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    tot_d      = tot_q;
    hi_d       = hi_q;
    gap_d      = gap_q;
    period_d   = period_q;
    high_d     = high_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    accumulate = 1'b0;

    if (start) begin
      state_d    = ST_ARM;
      gap_d      = '0;
      timeout_d  = 1'b0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_ARM: begin
          if (rise) begin
            state_d    = ST_COUNT;
            edge_cnt_d = '0;
            tot_d      = CNT_W'(1);
            hi_d       = CNT_W'(1);
            gap_d      = '0;
          end else if (gap_hit) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
          end else begin
            gap_d = gap_inc;
          end
        end
        ST_COUNT, ST_DONE: begin
          if (state_q == ST_DONE && !cont_mode) begin
            state_d = ST_IDLE;
          end else if (rise && last_edge) begin
            // The capturing rise also opens the next window, so tot/hi restart at one.
            period_d   = tot_q;
            high_d     = hi_q;
            state_d    = ST_DONE;
            edge_cnt_d = '0;
            tot_d      = CNT_W'(1);
            hi_d       = CNT_W'(1);
            gap_d      = '0;
          end else if (rise) begin
            state_d    = ST_COUNT;
            edge_cnt_d = edge_inc[N_W-1:0];
            gap_d      = '0;
            accumulate = 1'b1;
          end else if (gap_hit) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
          end else begin
            state_d    = ST_COUNT;
            gap_d      = gap_inc;
            accumulate = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (accumulate) begin
      tot_d = tot_inc;
      hi_d  = hi_inc;
      if (tot_inc == CNT_MAX || hi_inc == CNT_MAX) begin
        overflow_d = 1'b1;
      end
    end
  end

  // State, counter, result and flag registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      edge_cnt_q <= '0;
      tot_q      <= '0;
      hi_q       <= '0;
      gap_q      <= '0;
      period_q   <= '0;
      high_q     <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      tot_q      <= tot_d;
      hi_q       <= hi_d;
      gap_q      <= gap_d;
      period_q   <= period_d;
      high_q     <= high_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy         = (state_q == ST_ARM) || (state_q == ST_COUNT);
  assign done         = (state_q == ST_DONE);
  assign timeout      = timeout_q;
  assign overflow     = overflow_q;
  assign period_total = period_q;
  assign high_total   = high_q;

endmodule

// File: rtl/square_wave_meter.sv
// Multi-channel equal-precision period and duty meter; latches the request and fans it out.
module square_wave_meter
  import square_meter_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 200_000_000,
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int N_W          = DEF_N_W,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_CYC  = clk_to_timeout(SYS_CLK_FREQ, 10)
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [NUM_CH-1:0]       wave_in,
  input  logic [N_W-1:0]          n_periods,
  input  logic                    start,
  input  logic                    continuous,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       timeout,
  output logic [NUM_CH-1:0]       overflow,
  output logic [NUM_CH*CNT_W-1:0] period_total,
  output logic [NUM_CH*CNT_W-1:0] high_total
);

  logic [N_W-1:0] n_lat_q;
  logic           cont_q;

  // Capture the request on start; a zero period count would never finish, so it becomes one.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      n_lat_q <= N_W'(1);
      cont_q  <= 1'b0;
    end else if (start) begin
      n_lat_q <= (n_periods == '0) ? N_W'(1) : n_periods;
      cont_q  <= continuous;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    square_wave_meter_ch #(
      .CNT_W       (CNT_W),
      .N_W         (N_W),
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_ch (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .wave_in      (wave_in[i]),
      .start        (start),
      .n_req        (n_lat_q),
      .cont_mode    (cont_q),
      .busy         (busy[i]),
      .done         (done[i]),
      .timeout      (timeout[i]),
      .overflow     (overflow[i]),
      .period_total (period_total[i*CNT_W +: CNT_W]),
      .high_total   (high_total[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: doc/square_wave_meter.md
Name: square_wave_meter

Overview:
- Parametrised multi-channel, equal-precision period and duty meter.
- Each channel synchronises its square-wave input and counts N full input periods, starting on a rising edge.
- Over that window it reports the total clock count and the high-level clock count; software derives frequency and duty from these.
- Sits between the comparator/input pins and the MCU readout register bank; adds single-shot/continuous modes, timeout and overflow flags.

Parameters:
- SYS_CLK_FREQ, 200_000_000, measurement clock frequency in Hz (documentation and TIMEOUT_CYC default only).
- NUM_CH, 2, number of independent input channels (1..8).
- CNT_W, 32, width of the period and high-time counters.
- N_W, 16, width of the period-count request.
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- TIMEOUT_CYC, SYS_CLK_FREQ/10, maximum clocks between consecutive rising edges before abort.

Ports:
- sys_clk  in  1  measurement clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- wave_in  in  NUM_CH  asynchronous square-wave inputs, bit i = channel i.
- n_periods  in  N_W  periods per measurement; sampled on start.
- start  in  1  one-cycle pulse: arm all channels.
- continuous  in  1  1 = re-arm automatically after each result; sampled on start.
- busy  out  NUM_CH  channel i is in ARM or COUNT.
- done  out  NUM_CH  one-cycle pulse: channel i result updated.
- timeout  out  NUM_CH  sticky; channel i aborted for lack of edges; cleared by next start.
- overflow  out  NUM_CH  sticky; channel i counter saturated in the last result; cleared by next start.
- period_total  out  NUM_CH*CNT_W  channel i at [i*CNT_W +: CNT_W]: clocks spanning N periods.
- high_total  out  NUM_CH*CNT_W  same packing: clocks with the input high inside that window.

Behaviour:
- Reset (asynchronous, any state): all outputs 0, all channels IDLE, synchroniser flops 0, latched N = 1.
- Synchroniser and edge detect:
  - Input passes SYNC_STAGES flops, then one previous-level flop.
  - A rise is asserted in the cycle where level=1 and prev=0.
  - Edge-to-rise latency is SYNC_STAGES+1 clocks (constant, so it cancels in differences).
- start:
  - Latches n_periods into N; N = 0 is coerced to 1.
  - Latches continuous, clears timeout and overflow, and moves every channel to ARM, including a channel that is mid-measurement.
  - Held results are not cleared.
- Per-channel FSM:
  - IDLE: busy=0; waits for start.
  - ARM: busy=1. On rise: edge_cnt=0, tot=1, hi=1, go to COUNT. A rise in the same cycle as start is ignored (ARM is entered next cycle).
  - COUNT, each cycle without rise: tot += 1; hi += level.
  - COUNT, rise with edge_cnt+1 < N: edge_cnt += 1; tot += 1; hi += level.
  - COUNT, rise with edge_cnt+1 == N: capture period_total = tot and high_total = hi; pulse done next cycle; go to DONE.
  - DONE (1 cycle): if continuous, go to COUNT with tot=1, hi=1, edge_cnt=0, reusing the capturing rise as the new window start so no period is lost. Otherwise go to IDLE.
- Required window values:
  - period_total = number of cycles from the first rise cycle (inclusive) to the N-th subsequent rise cycle (exclusive).
  - high_total = cycles inside that window with level=1.
  - Example: period 10 clocks, high 3 clocks, N=1 -> 10 and 3.
- Timeout:
  - A gap counter, reset on every rise, runs in ARM and COUNT.
  - Reaching TIMEOUT_CYC sets timeout, returns the channel to IDLE (continuous is ignored), leaves results unchanged and produces no done pulse.
- Saturation: tot and hi stop at all-ones. Reaching all-ones sets overflow; the capture still happens with the saturated values.
- Channel independence: a timeout or overflow on one channel does not affect the others.
- Simultaneous start and capture: start wins. No done pulse and no result update for that cycle.

Decomposition:
- Shared package/header square_meter_pkg:
  - FSM state encodings ST_IDLE, ST_ARM, ST_COUNT, ST_DONE.
  - Default CNT_W and N_W.
  - A function that converts clocks to timeout cycles.
- Sub-module square_wave_meter_ch:
  - Contains the synchroniser, edge detect, FSM, counters and flags for one channel.
  - The top instantiates it NUM_CH times in a generate loop and fans out start, N and continuous.

Test Plan:
- Ch0 period 10 clocks / high 3 clocks, n_periods=4, single-shot start -> one done pulse; period_total=40, high_total=12; busy drops after DONE.
- n_periods=0 with a 7/4 clock wave -> treated as N=1; result 7 and 4.
- continuous=1 with a 20/10 clock wave, N=2 -> done every 40 clocks; every result 40/20; no gap between windows.
- Ch0 at 12 clocks and ch1 at 50 clocks, N=3 -> independent done pulses with 36 and 150; ch1 held at constant level -> ch1 timeout=1 after TIMEOUT_CYC, ch0 unaffected.
- CNT_W=8, 300-clock period, N=1 -> overflow=1, period_total=255, done asserted.
- Reset asserted mid-COUNT, then released -> all outputs 0, IDLE. A new start yields a correct result. A start pulsed mid-COUNT restarts that window.
